// File: rtl/mem_wait_responder_if.sv
// Request/response bundle between the multicycle control unit (master)
// and the wait-state memory responder (slave).
interface mem_wait_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        addr_err;

    modport master (output req, we, addr, wdata, input rdata, ready, busy, addr_err);
    modport slave  (input req, we, addr, wdata, output rdata, ready, busy, addr_err);
endinterface

// File: rtl/mem_wait_responder.sv
// Word-addressed memory that answers one request at a time after WAIT_CYCLES
// wait states, with a one-cycle ready pulse and an address-error flag.
module mem_wait_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_wait_responder_if.slave  bus
);
    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam int          CW         = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t        state;
    logic [CW-1:0] cnt;
    req_t          lat;
    req_t          cur;
    logic          commit;
    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH_WORDS];

    // With zero wait states the commit happens on the accept edge itself, so
    // the live bus inputs are used in IDLE and the latched copy otherwise.
    always_comb begin
        cur    = (state == IDLE) ? '{we: bus.we, addr: bus.addr, wdata: bus.wdata} : lat;
        commit = 1'b0;
        if (reset) begin
            if (state == IDLE)      commit = bus.req && (WAIT_CYCLES == 0);
            else if (state == WAIT) commit = (cnt == CW'(1));
        end
        err = (cur.addr[1:0] != 2'b00) || (cur.addr >= ADDR_LIMIT);
        idx = cur.addr[AW+1:2];
    end

    // Array has no reset: contents survive reset, only uncommitted writes are lost.
    always_ff @(posedge clk) begin
        if (commit && cur.we && !err) mem[idx] <= cur.wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat          <= '0;
            bus.rdata    <= '0;
            bus.ready    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.ready    <= 1'b0;
            bus.addr_err <= 1'b0;
            if (commit) begin
                bus.ready    <= 1'b1;
                bus.addr_err <= err;
                bus.rdata    <= err ? 32'h0 : (cur.we ? cur.wdata : mem[idx]);
            end
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        lat      <= cur;
                        bus.busy <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed plus randomized checks of two responder builds (2 and 0 wait states)
// against a word-array reference model.
module tb_mem_wait_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, we;
    logic [31:0] addr, wdata;
    bit          sel;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [2][64];

    always #5 clk = ~clk;

    mem_wait_responder_if ia ();
    mem_wait_responder_if ib ();

    assign ia.req = req_a;  assign ia.we = we;  assign ia.addr = addr;  assign ia.wdata = wdata;
    assign ib.req = req_b;  assign ib.we = we;  assign ib.addr = addr;  assign ib.wdata = wdata;

    mem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    mem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

    logic [31:0] o_rdata;
    logic        o_ready, o_busy, o_err;
    always_comb begin
        o_rdata = sel ? ib.rdata    : ia.rdata;
        o_ready = sel ? ib.ready    : ia.ready;
        o_busy  = sel ? ib.busy     : ia.busy;
        o_err   = sel ? ib.addr_err : ia.addr_err;
    end

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; inputs are scrambled right after acceptance.
    task automatic txn(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d, input string tag);
        int          lat;
        logic [31:0] er;
        bit          ee;
        lat = s ? 0 : 2;
        ee  = addr_bad(a);
        if (ee)     er = 32'h0;
        else if (w) begin er = d; mdl[s][a[7:2]] = d; end
        else        er = mdl[s][a[7:2]];
        @(negedge clk);
        sel = s; we = w; addr = a; wdata = d;
        if (s) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        we = 1'($urandom); addr = $urandom; wdata = $urandom;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, "_ready"}, 32'(o_ready), 32'(k == lat));
            chk({tag, "_busy"}, 32'(o_busy), 32'd1);
        end
        chk({tag, "_rdata"}, o_rdata, er);
        chk({tag, "_err"}, 32'(o_err), 32'(ee));
        @(negedge clk);
        chk({tag, "_ready_low"}, 32'(o_ready), 32'd0);
        chk({tag, "_busy_low"}, 32'(o_busy), 32'd0);
        chk({tag, "_err_low"}, 32'(o_err), 32'd0);
        chk({tag, "_rdata_hold"}, o_rdata, er);
    endtask

    initial begin
        logic [31:0] a, d;
        bit          s;
        sel = 1'b0; reset = 1'b0; req_a = 1'b1; req_b = 1'b1;
        we = 1'b1; addr = 32'h10; wdata = 32'h5555AAAA;
        // Reset held with req asserted
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #0;
            chk("rst_ready", 32'(o_ready), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_rdata", o_rdata, 32'd0);
            chk("rst_err", 32'(o_err), 32'd0);
        end
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b0; #0;
        chk("post_rst_busy_a", 32'(o_busy), 32'd0);
        sel = 1'b1; #0;
        chk("post_rst_busy_b", 32'(o_busy), 32'd0);

        // Give every word a known value in both builds
        for (int i = 0; i < 64; i++) begin
            txn(1'b0, 1'b1, 32'(i * 4), $urandom, "init_a");
            txn(1'b1, 1'b1, 32'(i * 4), $urandom, "init_b");
        end

        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        txn(1'b0, 1'b0, 32'h10, 32'h0, "rd10");
        txn(1'b0, 1'b0, 32'h14, 32'h0, "rd14");
        txn(1'b0, 1'b1, 32'h12, 32'h12345678, "wr_misalign");
        txn(1'b0, 1'b0, 32'h10, 32'h0, "rd10_after_misalign");
        txn(1'b0, 1'b0, 32'h100, 32'h0, "rd_oor");
        txn(1'b0, 1'b0, 32'hFC, 32'h0, "rd_last");
        txn(1'b0, 1'b1, 32'hFFFFFFFC, 32'h0BADF00D, "wr_high");

        // req held high: a new transaction every WAIT_CYCLES+2 cycles
        @(negedge clk);
        sel = 1'b0; we = 1'b0; addr = 32'h10; req_a = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_ready", 32'(o_ready), 32'((k % 4) == 2));
            chk("hold_busy", 32'(o_busy), 32'((k % 4) != 3));
            if ((k % 4) == 2) chk("hold_rdata", o_rdata, mdl[0][4]);
        end
        req_a = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during WAIT discards the write
        we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midwait_ready", 32'(o_ready), 32'd0);
        chk("midwait_busy", 32'(o_busy), 32'd0);
        chk("midwait_rdata", o_rdata, 32'd0);
        chk("midwait_err", 32'(o_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 1'b0, 32'h20, 32'h0, "rd20_after_rst");

        // Reset during RESP keeps the committed write
        @(negedge clk);
        we = 1'b1; addr = 32'h24; wdata = 32'h600DCAFE; req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("resp_ready_pre", 32'(o_ready), 32'd1);
        reset = 1'b0;
        #1 chk("resp_ready_drop", 32'(o_ready), 32'd0);
        mdl[0][9] = 32'h600DCAFE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 1'b0, 32'h24, 32'h0, "rd24_after_rst");

        // Zero-wait build
        txn(1'b1, 1'b1, 32'h10, 32'h13579BDF, "b_wr10");
        txn(1'b1, 1'b0, 32'h10, 32'h0, "b_rd10");
        txn(1'b1, 1'b0, 32'h104, 32'h0, "b_rd_oor");

        // Random mix of builds, directions and address classes
        repeat (80) begin
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0, 1: a = 32'($urandom_range(0, 63)) << 2;
                2:    a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
                default: a = $urandom;
            endcase
            d = $urandom;
            txn(s, 1'($urandom), a, d, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Word-addressed data/instruction memory responder for the multicycle CPU's memory port.
- Services one request at a time (read or write) after a configurable number of wait states.
- Signals completion with a one-cycle ready pulse.
- Flags misaligned or out-of-range byte addresses so the control unit can raise an exception.
- Replaces the fixed-latency memory once the control unit moves to a request/ready handshake.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words stored; power of two, minimum 4
WAIT_CYCLES, 2, clock edges from request acceptance to entering the response state; 0 allowed

Ports:
clk      input   1   system clock, rising-edge active
reset    input   1   asynchronous, active-low reset (0 = reset asserted)
req      input   1   request strobe from control unit; sampled only in IDLE
we       input   1   1 = write, 0 = read; sampled with req
addr     input   32  byte address; sampled with req
wdata    input   32  write data; sampled with req
rdata    output  32  read data; valid while ready=1, held until next response
ready    output  1   one-cycle pulse: request complete
busy     output  1   1 whenever state != IDLE
addr_err output  1   valid with ready: 1 = misaligned or out-of-range address

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, rdata=0, ready=0, busy=0, addr_err=0, latched request cleared. The memory array is not cleared.
- States:
  - IDLE: if req=1 at a rising edge (the accept edge T0), latch we/addr/wdata. Go to RESP if WAIT_CYCLES=0, else go to WAIT with counter=WAIT_CYCLES.
  - WAIT: counter decrements each edge. At the edge where counter==1, commit and go to RESP.
  - RESP: ready=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency: RESP is entered at edge T0+WAIT_CYCLES, so ready is high during the cycle following that edge. Error responses have the same latency.
- Commit (on the edge entering RESP):
  - Address index = addr[log2(DEPTH_WORDS)+1:2].
  - Error when addr[1:0]!=0, or when addr >= DEPTH_WORDS*4 (unsigned, full 32 bits).
  - On error: no array write, rdata<=0, addr_err<=1.
  - Else, write: mem[index]<=wdata, rdata<=wdata (write-through echo), addr_err<=0.
  - Else, read: rdata<=mem[index], addr_err<=0.
- Outputs: ready and addr_err are registered; addr_err returns to 0 when leaving RESP. rdata holds its value until the next commit.
- req while busy (WAIT or RESP) is ignored. Holding req high continuously gives one transaction per WAIT_CYCLES+2 cycles: the request is re-accepted on the first IDLE edge.
- addr/we/wdata changes after T0 have no effect on the in-flight transaction.
- Read after write to the same address returns the new data (commits are strictly ordered).
- Reset mid-WAIT: any uncommitted write is discarded and the array is unchanged. Reset during RESP: ready drops immediately; the already-committed write is kept.
- Counter width: clog2(WAIT_CYCLES+1), minimum 1 bit. No wrap, because the counter never decrements below 1.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with req=1 -> ready=0, busy=0, rdata=0x00000000, addr_err=0. Release reset with req=0 -> state stays IDLE.
2. Write then read (WAIT_CYCLES=2): req, we=1, addr=0x10, wdata=0xDEADBEEF at T0 -> busy=1 after T0, ready=1 only in the cycle after T2, addr_err=0. Then read 0x10 -> rdata=0xDEADBEEF with ready. Read 0x14 (never written) returns stored contents unchanged.
3. Misaligned write: addr=0x12, wdata=0x12345678 -> ready with addr_err=1, rdata=0. A subsequent read of 0x10 still returns 0xDEADBEEF.
4. Out-of-range read: addr=0x00000100 with DEPTH_WORDS=64 -> addr_err=1, rdata=0. addr=0x000000FC -> addr_err=0 (last word).
5. req held high for 10 cycles: read addr=0x10 -> exactly two ready pulses, at cycles T0+3 and T0+7. busy=0 only in the IDLE cycles between them.
6. Reset mid-operation: write 0xCAFEF00D to 0x20, assert reset=0 one cycle after T0 (during WAIT) -> outputs zero immediately. After release, read 0x20 returns its prior value, not 0xCAFEF00D.
7. WAIT_CYCLES=0 build: read 0x10 -> ready in the cycle directly after T0, correct data.
